spi_slave_meas: RTL and testbench
=================================

# spi_slave_meas

Parametrised SPI slave for the relative-info front end, successor to the fixed pre-SPI receiver. It oversamples `cs_n`, `sclk` and `mosi` in the `clk` domain and supports all four CPOL/CPHA modes and configurable word width. It handles multi-word frames with a tx valid/ready handshake and an rx valid pulse. It also measures the SCLK period in `clk` cycles (`cycles_num`), which downstream logic uses to sanity-check the link rate.

## Interface
- DATA_W, 8, bits per SPI word (≥2)
- CNT_W, 16, width of `cycles_num` measurement counter
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- SYNC_STAGES, 2, synchroniser depth for `cs_n`/`sclk`/`mosi` (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cs_n  in  1  chip select, active low, asynchronous to `clk`
- sclk  in  1  SPI clock, asynchronous to `clk`
- mosi  in  1  master data in
- miso  out  1  slave data out, registered, MSB first
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  `tx_data` valid
- tx_ready  out  1  1-cycle pulse: `tx_data` consumed this cycle
- tx_underrun  out  1  1-cycle pulse: load occurred with `tx_valid`=0
- rx_data  out  DATA_W  last complete received word, held until next
- rx_valid  out  1  1-cycle pulse: `rx_data` updated
- frame_abort  out  1  1-cycle pulse: `cs_n` rose mid-word
- cycles_num  out  CNT_W  `clk` cycles between last two sample edges, saturating
- cycles_num_rdy  out  1  1-cycle pulse: `cycles_num` updated

## Operation
- `cs_n`, `sclk`, `mosi` each pass through SYNC_STAGES flops. Edges are detected by comparing the last stage with one further delayed copy. `mosi` is taken from the same stage as `sclk`.
- Leading edge = rising if CPOL=0, else falling. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- States: WAIT_HIGH, IDLE, ACTIVE.
- Reset enters WAIT_HIGH. WAIT_HIGH → IDLE when synced `cs_n`=1. IDLE → ACTIVE on synced `cs_n` falling edge. ACTIVE → IDLE on synced `cs_n` rising edge.
- Entering ACTIVE:
  - rx bit counter and tx bit counter cleared.
  - Period counter cleared; first-sample flag set.
  - If CPHA=0, tx shift register loaded (see load rule).
- Load rule:
  - If `tx_valid`: shreg ← `tx_data`, `tx_ready` pulses.
  - Else: shreg ← 0, `tx_underrun` pulses.
- Sample edge in ACTIVE:
  - rx shreg ← {rx shreg[DATA_W-2:0], mosi}; rx bit counter increments.
  - When the counter reaches DATA_W: `rx_data` ← assembled word, `rx_valid` pulses, counter → 0.
- Shift edge in ACTIVE:
  - CPHA=0: the DATA_W-th shift edge of a word performs a load; all others shift left.
  - CPHA=1: a shift edge with tx bit counter=0 performs a load; all others shift left.
  - The tx bit counter wraps at DATA_W.
- `miso` = tx shreg MSB in ACTIVE, 0 in IDLE/WAIT_HIGH. No tristate.
- Measurement:
  - Period counter increments every `clk` in ACTIVE and saturates at 2^CNT_W−1.
  - On each sample edge: if the first-sample flag is set, clear it; else `cycles_num` ← counter and `cycles_num_rdy` pulses. In both cases the counter restarts at 1 on the next cycle.
- `cs_n` rising with rx bit counter ≠ 0: partial word discarded, no `rx_valid`, `frame_abort` pulses. A rising edge on a word boundary ends the frame cleanly.
- No rx backpressure. `rx_data` is overwritten on the next complete word.

## Timing
- Reset values:
  - `miso`, `tx_ready`, `tx_underrun`, `rx_valid`, `frame_abort`, `cycles_num_rdy` = 0.
  - `rx_data` = 0, `cycles_num` = 0.
  - State = WAIT_HIGH; synchronisers cleared to the idle levels (`cs_n`=1, `sclk`=CPOL).
- Reset mid-frame: outputs return to reset values immediately. No frame starts until `cs_n` is seen high and then falling.
- Latency: a pin transition first sampled at `clk` edge N affects registered outputs at edge N+SYNC_STAGES+1.
- `rx_valid` follows the final sample edge with that latency. `miso` updates with the same latency after a load or shift edge.
- Guaranteed operation requires f_clk ≥ 8·f_sclk and `cs_n` setup/hold ≥ one SCLK half-period.
- Simultaneous `cs_n` rise and sample edge in the same cycle: `cs_n` wins and the edge is ignored.
- All pulses are exactly one `clk` cycle.

## Test plan
- Mode 0, DATA_W=8, clk 10 ns, sclk 100 ns, `tx_data`=0xA5 held valid, master sends 0x3C → `tx_ready` one pulse at frame start; `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C with one `rx_valid` pulse; `cycles_num`=10 with 7 `cycles_num_rdy` pulses.
- Two-word frame, tx 0x12 then 0x34, mosi 0xF0, 0x0F → `rx_valid` twice (0xF0, 0x0F); `miso` carries 0x12 then 0x34; `tx_ready` twice; 15 `cycles_num_rdy` pulses, all 10.
- Repeat scenario 1 with CPOL=1/CPHA=1 and with CPOL=0/CPHA=1 → identical `rx_data`, `miso` bit sequence and `cycles_num`.
- `cs_n` released after 5 bits → no `rx_valid`, one `frame_abort`; the following full frame with 0x3C yields `rx_data`=0x3C.
- `tx_valid`=0 at frame start → `miso` all 0, one `tx_underrun`, no `tx_ready`, rx still 0x3C.
- CNT_W=4, sclk 400 ns → `cycles_num`=15 (saturated). `rst` pulsed mid-frame with `cs_n` held low → all outputs 0 and no `rx_valid` until `cs_n` toggles high then low.

Source files
------------

// File: rtl/spi_slave_meas.sv
// SPI slave (any CPOL/CPHA, DATA_W-bit words) with SCLK period measurement; pins land on outputs
// SYNC_STAGES+1 clk edges after first sampling. No rx backpressure; tx is pulled by tx_ready/tx_underrun.
module spi_slave_meas #(
   parameter int DATA_W      = 8,
   parameter int CNT_W       = 16,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_underrun,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_abort,
   output logic [CNT_W-1:0]  cycles_num,
   output logic              cycles_num_rdy
);
   localparam logic              SCLK_IDLE = (CPOL != 0);
   localparam int                BCNT_W    = $clog2(DATA_W);
   localparam int                FILL_W    = SYNC_STAGES + 2;
   localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  PER_MAX   = '1;

   typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE} state_t;
   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
   logic                   r_cs_d, r_sclk_d;
   logic                   r_cs_rise, r_cs_fall, r_samp, r_shift, r_mosi_bit;
   logic [FILL_W-1:0]      r_fill;
   logic                   w_cs, w_sclk, w_lead, w_trail;

   logic [DATA_W-1:0]      r_tx_sh, w_tx_sh_nxt, r_rx_data;
   logic [DATA_W-2:0]      r_rx_sh;
   logic [DATA_W-1:0]      w_rx_word;
   logic [BCNT_W-1:0]      r_tx_cnt, w_tx_cnt_nxt, r_rx_cnt;
   logic [CNT_W-1:0]       r_per, r_cycles;
   logic                   r_first, r_miso, r_tx_ready, r_tx_underrun;
   logic                   r_rx_valid, r_frame_abort, r_cycles_rdy;
   logic                   w_enter, w_act, w_load, w_load_pt;

   assign w_cs    = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
   assign w_lead  = SCLK_IDLE ? (r_sclk_d & ~w_sclk) : (~r_sclk_d & w_sclk);
   assign w_trail = SCLK_IDLE ? (~r_sclk_d & w_sclk) : (r_sclk_d & ~w_sclk);

   // Edge strobes are registered so every pin event reaches the outputs one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
         r_mosi_sync <= '0;
         r_cs_d      <= 1'b1;
         r_sclk_d    <= SCLK_IDLE;
         r_cs_rise   <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_samp      <= 1'b0;
         r_shift     <= 1'b0;
         r_mosi_bit  <= 1'b0;
         r_fill      <= '0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_cs_d      <= w_cs;
         r_sclk_d    <= w_sclk;
         r_cs_rise   <= w_cs & ~r_cs_d;
         r_cs_fall   <= ~w_cs & r_cs_d;
         r_samp      <= (CPHA != 0) ? w_trail : w_lead;
         r_shift     <= (CPHA != 0) ? w_lead : w_trail;
         r_mosi_bit  <= r_mosi_sync[SYNC_STAGES-1];
         r_fill      <= {r_fill[FILL_W-2:0], 1'b1};
      end
   end

   // WAIT_HIGH holds off until the pipeline carries real pin values, so a cs_n
   // held low through reset can never look like a fresh falling edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_HIGH: if (r_fill[FILL_W-1] && r_cs_d) w_state_nxt = IDLE;
         IDLE:      if (r_cs_fall) w_state_nxt = ACTIVE;
         ACTIVE:    if (r_cs_rise) w_state_nxt = IDLE;
         default:   w_state_nxt = WAIT_HIGH;
      endcase
   end

   assign w_enter   = (r_state == IDLE) && (w_state_nxt == ACTIVE);
   assign w_act     = (r_state == ACTIVE) && !r_cs_rise;
   assign w_load_pt = (CPHA != 0) ? (r_tx_cnt == '0) : (r_tx_cnt == LAST_BIT);
   assign w_rx_word = {r_rx_sh, r_mosi_bit};

   always_comb begin
      w_tx_sh_nxt  = r_tx_sh;
      w_tx_cnt_nxt = r_tx_cnt;
      w_load       = 1'b0;
      if (w_enter) begin
         w_tx_cnt_nxt = '0;
         w_tx_sh_nxt  = '0;
         w_load       = (CPHA == 0);
      end else if (w_act && r_shift) begin
         w_tx_cnt_nxt = (r_tx_cnt == LAST_BIT) ? '0 : r_tx_cnt + 1'b1;
         if (w_load_pt) w_load = 1'b1;
         else           w_tx_sh_nxt = {r_tx_sh[DATA_W-2:0], 1'b0};
      end
      if (w_load) w_tx_sh_nxt = tx_valid ? tx_data : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= WAIT_HIGH;
         r_tx_sh       <= '0;
         r_tx_cnt      <= '0;
         r_rx_sh       <= '0;
         r_rx_cnt      <= '0;
         r_rx_data     <= '0;
         r_per         <= '0;
         r_first       <= 1'b0;
         r_cycles      <= '0;
         r_miso        <= 1'b0;
         r_tx_ready    <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_rx_valid    <= 1'b0;
         r_frame_abort <= 1'b0;
         r_cycles_rdy  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_tx_sh       <= w_tx_sh_nxt;
         r_tx_cnt      <= w_tx_cnt_nxt;
         r_miso        <= (w_state_nxt == ACTIVE) ? w_tx_sh_nxt[DATA_W-1] : 1'b0;
         r_tx_ready    <= w_load & tx_valid;
         r_tx_underrun <= w_load & ~tx_valid;
         r_rx_valid    <= 1'b0;
         r_cycles_rdy  <= 1'b0;
         r_frame_abort <= (r_state == ACTIVE) && r_cs_rise && (r_rx_cnt != '0);
         if (w_enter) begin
            r_rx_cnt <= '0;
            r_per    <= '0;
            r_first  <= 1'b1;
         end else if (w_act && r_samp) begin
            r_rx_sh <= w_rx_word[DATA_W-2:0];
            if (r_rx_cnt == LAST_BIT) begin
               r_rx_cnt   <= '0;
               r_rx_data  <= w_rx_word;
               r_rx_valid <= 1'b1;
            end else begin
               r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            // The first sample edge of a frame has no predecessor to measure against.
            r_per   <= CNT_W'(1);
            r_first <= 1'b0;
            if (!r_first) begin
               r_cycles     <= r_per;
               r_cycles_rdy <= 1'b1;
            end
         end else if ((r_state == ACTIVE) && (r_per != PER_MAX)) begin
            r_per <= r_per + 1'b1;
         end
      end
   end

   assign miso           = r_miso;
   assign tx_ready       = r_tx_ready;
   assign tx_underrun    = r_tx_underrun;
   assign rx_data        = r_rx_data;
   assign rx_valid       = r_rx_valid;
   assign frame_abort    = r_frame_abort;
   assign cycles_num     = r_cycles;
   assign cycles_num_rdy = r_cycles_rdy;
endmodule

// File: tb/tb_spi_slave_meas.sv
// Directed bench for spi_slave_meas: four instances (modes 0, 3, 1 and a CNT_W=4 mode-0 copy)
// share cs_n/mosi/tx inputs; each scenario clocks only the selected instance's sclk.
module tb_spi_slave_meas;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, cs_n, mosi, tx_valid;
   logic [7:0] tx_data;
   logic [3:0] sclk_a;
   logic [3:0] miso_a, txr_a, txu_a, rxv_a, fab_a, cnr_a;
   logic [7:0] rxd_a [4];
   logic [15:0] cn_a [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int P_CPOL = (g == 1) ? 1 : 0;
      localparam int P_CPHA = (g == 1 || g == 2) ? 1 : 0;
      localparam int P_CNTW = (g == 3) ? 4 : 16;
      logic [P_CNTW-1:0] w_cn;
      spi_slave_meas #(.DATA_W(8), .CNT_W(P_CNTW), .CPOL(P_CPOL), .CPHA(P_CPHA), .SYNC_STAGES(2)) u_dut (
         .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk_a[g]), .mosi(mosi), .miso(miso_a[g]),
         .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_a[g]), .tx_underrun(txu_a[g]),
         .rx_data(rxd_a[g]), .rx_valid(rxv_a[g]), .frame_abort(fab_a[g]),
         .cycles_num(w_cn), .cycles_num_rdy(cnr_a[g])
      );
      assign cn_a[g] = 16'(w_cn);
   end

   int n_txr[4] = '{0, 0, 0, 0};
   int n_txu[4] = '{0, 0, 0, 0};
   int n_rxv[4] = '{0, 0, 0, 0};
   int n_fab[4] = '{0, 0, 0, 0};
   int n_rdy[4] = '{0, 0, 0, 0};
   int n_cnbad[4] = '{0, 0, 0, 0};
   logic [7:0]  rx_last[4] = '{8'h0, 8'h0, 8'h0, 8'h0};
   logic [7:0]  rx_prev[4] = '{8'h0, 8'h0, 8'h0, 8'h0};
   logic [15:0] cn_exp;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (txr_a[i] === 1'b1) n_txr[i]++;
         if (txu_a[i] === 1'b1) n_txu[i]++;
         if (fab_a[i] === 1'b1) n_fab[i]++;
         if (rxv_a[i] === 1'b1) begin
            rx_prev[i] = rx_last[i];
            rx_last[i] = rxd_a[i];
            n_rxv[i]++;
         end
         if (cnr_a[i] === 1'b1) begin
            n_rdy[i]++;
            if (cn_a[i] !== cn_exp) n_cnbad[i]++;
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [15:0] miso_cap;
   int          txr_snap;

   // Master: miso is captured just before each sample edge; tx_data switches to tx2
   // once the first word is loaded. txr_snap is taken before the frame's last edge.
   task automatic spi_frame(input int sel, input int nbits, input logic [15:0] mosi_w,
                            input logic [7:0] tx2, input int half);
      logic pol, pha;
      pol = (sel == 1);
      pha = (sel == 1 || sel == 2);
      miso_cap = '0;
      @(posedge clk);
      #3;
      if (!pha) mosi = mosi_w[nbits-1];
      cs_n = 1'b0;
      #(2 * half);
      for (int b = 0; b < nbits; b++) begin
         if (!pha) begin
            miso_cap = {miso_cap[14:0], miso_a[sel]};
            sclk_a[sel] = ~pol;
            #half;
            if (b == nbits - 1) txr_snap = n_txr[sel];
            sclk_a[sel] = pol;
            mosi = (b < nbits - 1) ? mosi_w[nbits-2-b] : 1'b0;
            #half;
         end else begin
            sclk_a[sel] = ~pol;
            mosi = mosi_w[nbits-1-b];
            #half;
            miso_cap = {miso_cap[14:0], miso_a[sel]};
            if (b == nbits - 1) txr_snap = n_txr[sel];
            sclk_a[sel] = pol;
            #half;
         end
         if (b == 0) tx_data = tx2;
      end
      cs_n = 1'b1;
      #(4 * half);
   endtask

   int b_txr, b_txu, b_rxv, b_fab, b_rdy, b_bad;

   task automatic snap(input int sel);
      b_txr = n_txr[sel]; b_txu = n_txu[sel]; b_rxv = n_rxv[sel];
      b_fab = n_fab[sel]; b_rdy = n_rdy[sel]; b_bad = n_cnbad[sel];
   endtask

   initial begin
      rst = 1'b1; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      sclk_a = 4'b0010;
      cn_exp = 16'd10;
      repeat (5) @(posedge clk);
      #1;
      check("reset_pulses", {26'd0, miso_a[0], txr_a[0], txu_a[0], rxv_a[0], fab_a[0], cnr_a[0]}, 32'd0);
      check("reset_rx_data", {24'd0, rxd_a[0]}, 32'd0);
      check("reset_cycles", {16'd0, cn_a[0]}, 32'd0);
      rst = 1'b0;
      repeat (10) @(posedge clk);

      // Mode 0, single word
      tx_data = 8'hA5; tx_valid = 1'b1;
      snap(0);
      spi_frame(0, 8, 16'h003C, 8'hA5, 50);
      check("m0_miso", {24'd0, miso_cap[7:0]}, 32'hA5);
      check("m0_rx_data", {24'd0, rx_last[0]}, 32'h3C);
      check("m0_rx_valid_n", n_rxv[0] - b_rxv, 32'd1);
      check("m0_tx_ready_start", txr_snap - b_txr, 32'd1);
      check("m0_rdy_n", n_rdy[0] - b_rdy, 32'd7);
      check("m0_cycles", {16'd0, cn_a[0]}, 32'd10);
      check("m0_cycles_bad", n_cnbad[0] - b_bad, 32'd0);
      check("m0_abort_n", n_fab[0] - b_fab, 32'd0);

      // Mode 0, two-word frame
      tx_data = 8'h12;
      snap(0);
      spi_frame(0, 16, 16'hF00F, 8'h34, 50);
      check("w2_miso", {16'd0, miso_cap}, 32'h1234);
      check("w2_rx_first", {24'd0, rx_prev[0]}, 32'hF0);
      check("w2_rx_second", {24'd0, rx_last[0]}, 32'h0F);
      check("w2_rx_valid_n", n_rxv[0] - b_rxv, 32'd2);
      check("w2_tx_ready_n", txr_snap - b_txr, 32'd2);
      check("w2_rdy_n", n_rdy[0] - b_rdy, 32'd15);
      check("w2_cycles_bad", n_cnbad[0] - b_bad, 32'd0);

      // Modes 3 and 1 must match mode 0
      for (int s = 1; s <= 2; s++) begin
         tx_data = 8'hA5;
         snap(s);
         spi_frame(s, 8, 16'h003C, 8'hA5, 50);
         check($sformatf("mode%0d_miso", (s == 1) ? 3 : 1), {24'd0, miso_cap[7:0]}, 32'hA5);
         check($sformatf("mode%0d_rx_data", (s == 1) ? 3 : 1), {24'd0, rxd_a[s]}, 32'h3C);
         check($sformatf("mode%0d_rx_valid_n", (s == 1) ? 3 : 1), n_rxv[s] - b_rxv, 32'd1);
         check($sformatf("mode%0d_tx_ready_n", (s == 1) ? 3 : 1), txr_snap - b_txr, 32'd1);
         check($sformatf("mode%0d_rdy_n", (s == 1) ? 3 : 1), n_rdy[s] - b_rdy, 32'd7);
         check($sformatf("mode%0d_cycles", (s == 1) ? 3 : 1), {16'd0, cn_a[s]}, 32'd10);
      end

      // Abort after 5 bits, then a clean frame
      snap(0);
      spi_frame(0, 5, 16'h0015, 8'hA5, 50);
      check("abort_n", n_fab[0] - b_fab, 32'd1);
      check("abort_rx_valid_n", n_rxv[0] - b_rxv, 32'd0);
      check("abort_rx_held", {24'd0, rxd_a[0]}, 32'h0F);
      snap(0);
      spi_frame(0, 8, 16'h003C, 8'hA5, 50);
      check("post_abort_rx", {24'd0, rxd_a[0]}, 32'h3C);
      check("post_abort_rx_valid_n", n_rxv[0] - b_rxv, 32'd1);

      // Underrun in mode 1: one load at the first leading edge, tx_valid low
      tx_valid = 1'b0;
      snap(2);
      spi_frame(2, 8, 16'h003C, 8'hA5, 50);
      check("ur_miso", {24'd0, miso_cap[7:0]}, 32'h00);
      check("ur_underrun_n", n_txu[2] - b_txu, 32'd1);
      check("ur_tx_ready_n", n_txr[2] - b_txr, 32'd0);
      check("ur_rx_valid_n", n_rxv[2] - b_rxv, 32'd1);
      check("ur_rx_data", {24'd0, rxd_a[2]}, 32'h3C);
      tx_valid = 1'b1;

      // CNT_W=4 with a 400-unit SCLK period saturates the measurement
      cn_exp = 16'd15;
      tx_data = 8'hA5;
      snap(3);
      spi_frame(3, 8, 16'h003C, 8'hA5, 200);
      check("sat_cycles", {16'd0, cn_a[3]}, 32'd15);
      check("sat_rdy_n", n_rdy[3] - b_rdy, 32'd7);
      check("sat_cycles_bad", n_cnbad[3] - b_bad, 32'd0);
      check("sat_rx_data", {24'd0, rxd_a[3]}, 32'h3C);
      check("sat_miso", {24'd0, miso_cap[7:0]}, 32'hA5);

      // Reset mid-frame with cs_n held low
      cn_exp = 16'd10;
      @(posedge clk);
      #3;
      cs_n = 1'b0;
      for (int b = 0; b < 3; b++) begin
         #50; sclk_a[0] = 1'b1; #50; sclk_a[0] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_pulses", {26'd0, miso_a[0], txr_a[0], txu_a[0], rxv_a[0], fab_a[0], cnr_a[0]}, 32'd0);
      check("midrst_rx_data", {24'd0, rxd_a[0]}, 32'd0);
      check("midrst_cycles", {16'd0, cn_a[0]}, 32'd0);
      rst = 1'b0;
      #2;
      snap(0);
      for (int b = 7; b >= 0; b--) begin
         mosi = b[0] ^ b[1];
         #50; sclk_a[0] = 1'b1; #50; sclk_a[0] = 1'b0;
      end
      #200;
      check("midrst_no_rx_valid", n_rxv[0] - b_rxv, 32'd0);
      check("midrst_no_tx_ready", n_txr[0] - b_txr, 32'd0);
      check("midrst_miso_low", {31'd0, miso_a[0]}, 32'd0);
      cs_n = 1'b1;
      #200;
      snap(0);
      spi_frame(0, 8, 16'h003C, 8'hA5, 50);
      check("midrst_recover_rx", {24'd0, rxd_a[0]}, 32'h3C);
      check("midrst_recover_n", n_rxv[0] - b_rxv, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
